// File: rtl/block_data_memory.sv
// ---------------------------------------------------------------------------
// block_data_memory
//
// Block-addressed main data memory serving the data cache's miss / write-back
// port. Each request (read XOR write) reads or writes one whole block. Every
// access takes a fixed LATENCY cycles. busywait is high for that whole time.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high; clears state, readdata and all blocks
//   read       block read request, held by the requester until busywait is low
//   write      block write request, held by the requester until busywait is low
//   address    block address ({tag, index})
//   writedata  block to write
//   readdata   registered read block, held until the next read commits
//   busywait   high while a request is pending or in progress
// ---------------------------------------------------------------------------
module block_data_memory #(
   parameter int LATENCY    = 5,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writedata,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  busywait
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   // The counter only needs to hold LATENCY-2; keep at least one bit.
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [CNT_W-1:0]        count;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic                    lat_write;
   logic                    latch_en;
   logic                    commit;
   logic                    req;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // read and write together is an illegal request and is ignored entirely.
   assign req = read ^ write;

   // NOTE: every output of a combinational block gets a default before the
   // case statement, otherwise a path that skips an assignment infers a latch.
   always_comb begin
      next_state = state;
      busywait   = 1'b0;
      latch_en   = 1'b0;
      commit     = 1'b0;
      unique case (state)
         IDLE: begin
            // Combinational so busywait rises in the cache's request cycle.
            busywait = req;
            if (req) begin
               latch_en   = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            busywait = 1'b1;
            if (count == '0) begin
               commit     = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            // One cycle with busywait low; a still-held request is not sampled.
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (reset) begin
         busywait = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count     <= '0;
         readdata  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
         // NOTE: the storage array is cleared by reset, so it is built from
         // flops rather than a RAM macro; a pending write is simply dropped.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (latch_en) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_write <= write;
            count     <= CNT_W'(LATENCY - 2);
         end else if (state == BUSY && count != '0) begin
            count <= count - 1'b1;
         end

         if (commit) begin
            if (lat_write) begin
               mem[lat_addr] <= lat_wdata;
            end else begin
               readdata <= mem[lat_addr];
            end
         end
      end
   end

endmodule
